montgomery_exp: RTL and testbench
=================================

# montgomery_exp

Modular exponentiation controller. It computes x^e mod m by driving an external Montgomery multiplier over its start/done handshake, acting as the initiator for that multiplier. It sits one level above the multiplier in the RSA datapath and receives operands already in the Montgomery domain. It does no arithmetic itself: every product is delegated to the multiplier, and this block sequences the operations and holds the accumulator.

## Interface
Parameters:
- WIDTH, 1024: operand and modulus width in bits.
- EXP_WIDTH, 1024: exponent width in bits; every exponent bit is processed.

Ports:
- clk  in  1  sole clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- in_x  in  WIDTH  base in Montgomery form (x·R mod m).
- in_e  in  EXP_WIDTH  exponent.
- in_m  in  WIDTH  modulus, odd.
- in_r  in  WIDTH  Montgomery one (R mod m).
- result  out  WIDTH  final accumulator; stable from done until the next accepted start.
- done  out  1  one-cycle pulse when result is valid.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- mult_start  out  1  one-cycle pulse to the multiplier.
- mult_a, mult_b, mult_m  out  WIDTH  multiplier operands; held stable from mult_start until mult_done.
- mult_result  in  WIDTH  multiplier output, a·b·R⁻¹ mod m.
- mult_done  in  1  multiplier completion; must not rise before the cycle after mult_start.

## Operation
- start, in_x, in_e, in_m and in_r are captured in the LOAD state. After capture, input changes are ignored.
- Algorithm (left-to-right square-and-multiply):
  - Initialise A = in_r.
  - For i = EXP_WIDTH-1 down to 0: A = A·A; then, if e[i] = 1, A = A·x.
- FSM states: IDLE, LOAD, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, CONV_ISSUE, CONV_WAIT, DONE.
- Transitions:
  - IDLE → LOAD on start.
  - LOAD → SQ_ISSUE.
  - SQ_ISSUE → SQ_WAIT.
  - SQ_WAIT, on mult_done: A ← mult_result, then go to MUL_ISSUE if e[i] = 1, otherwise advance.
  - MUL_ISSUE → MUL_WAIT.
  - MUL_WAIT, on mult_done: A ← mult_result, then advance.
  - Advance: if i > 0, decrement i and go to SQ_ISSUE; if i = 0, go to CONV_ISSUE when the macro is defined, otherwise go to DONE.
  - CONV_ISSUE → CONV_WAIT.
  - CONV_WAIT → DONE on mult_done.
  - DONE → IDLE.
- Bit index: a down-counter of width clog2(EXP_WIDTH), or an equivalent left-shifting exponent register. There is no leading-zero skipping, so the squaring count is always EXP_WIDTH.
- Operand routing:
  - Squaring: a = b = A.
  - Multiply: a = A, b = x.
  - Conversion: a = A, b = 1.
  - mult_m is always the captured m.
- Boundary conditions:
  - start while busy: ignored, with no effect on the running operation.
  - mult_done outside a WAIT state: ignored.
  - e = 0: result = in_r (Montgomery one), or 1 with the conversion step.
  - reset mid-operation: FSM returns to IDLE and mult_start drops low immediately. The multiplier shares reset, so no stale mult_done can reach a new operation.

## Timing
- Reset values: result = 0, done = 0, busy = 0, mult_start = 0, mult_a = mult_b = mult_m = 0, state = IDLE.
- Start acceptance: start sampled high at edge k gives LOAD during cycle k+1 and busy = 1 from cycle k+1.
- Multiplier launch: mult_start is high exactly during each ISSUE cycle. The WAIT state holds for W ≥ 1 cycles, ending in the cycle where mult_done = 1.
- Total latency from the start edge to the done cycle is 2 + Σ(1 + W_j) cycles over all multiplications j.
- Multiplication count: N = EXP_WIDTH + popcount(e), plus 1 with conversion.
- done and busy both fall to 0 on the cycle after DONE.

## Configuration
- MONTEXP_FINAL_CONVERT_EN defined: after the last bit, the block issues one extra multiplication A·1, so result is x^e mod m in the normal (non-Montgomery) domain.
- Not defined: CONV states are not compiled, and result is x^e·R mod m (Montgomery domain).

## Structure
- Package montexp_pkg:
  - FSM state enum.
  - Default WIDTH and EXP_WIDTH constants.
  - Localparam for the counter width.
- The multiplier is not instantiated here; the top level connects it, so the multiplier can be shared.
- One natural sub-module: montexp_exp_shifter, holding the exponent register, the bit counter, and the current-bit and last-bit flags.

## Test plan
Bench: behavioural Montgomery model with R = 2^WIDTH and a programmable done delay. Unless stated, WIDTH = 8, EXP_WIDTH = 4, m = 13, in_r = 9, in_x = 5 (which is 2 in Montgomery form).
- e = 5, model W = 3: result = 2 without the macro, 6 with it. 6 mult_start pulses (7 with the macro). done arrives 2 + 6·4 = 26 cycles after the start edge without the macro.
- e = 0: result = 9 without the macro, 1 with it. Exactly 4 squarings, with mult_a = mult_b on every pulse.
- e = 0xF: result = 7 without the macro, 8 with it. 8 multiplications.
- start pulsed again during SQ_WAIT of a running e = 5 operation: ignored, and the result is unchanged at 2.
- reset asserted mid MUL_WAIT: all outputs return to reset values asynchronously. A fresh e = 5 operation then yields 2 with the correct pulse count.
- Random W in 1..5 with spurious mult_done in ISSUE and IDLE cycles: result matches the reference model over 100 random (x, e) pairs with m = 13.

Source files
------------

// File: rtl/montexp_pkg.sv
// Shared types and sizing for the modular-exponentiation controller.
// Optional final conversion to the normal domain is enabled by MONTEXP_FINAL_CONVERT_EN.
package montexp_pkg;

   localparam int unsigned DEF_WIDTH     = 32'd1024;
   localparam int unsigned DEF_EXP_WIDTH = 32'd1024;

   function automatic int unsigned cnt_width(input int unsigned exp_width);
      return (exp_width > 32'd1) ? $clog2(exp_width) : 32'd1;
   endfunction

   localparam int unsigned DEF_CNT_WIDTH = cnt_width(DEF_EXP_WIDTH);

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_LOAD       = 4'd1,
      ST_SQ_ISSUE   = 4'd2,
      ST_SQ_WAIT    = 4'd3,
      ST_MUL_ISSUE  = 4'd4,
      ST_MUL_WAIT   = 4'd5,
`ifdef MONTEXP_FINAL_CONVERT_EN
      ST_CONV_ISSUE = 4'd7,
      ST_CONV_WAIT  = 4'd8,
`endif
      ST_DONE       = 4'd6
   } state_e;

endpackage

// File: rtl/montgomery_exp_if.sv
// Start/done handshake and operand bus between the exponentiation controller and
// an external Montgomery multiplier; the controller is the master.
interface montgomery_exp_if
   import montexp_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);
   logic             mult_start;
   logic [WIDTH-1:0] mult_a;
   logic [WIDTH-1:0] mult_b;
   logic [WIDTH-1:0] mult_m;
   logic [WIDTH-1:0] mult_result;
   logic             mult_done;

   modport master (
      output mult_start, mult_a, mult_b, mult_m,
      input  mult_result, mult_done
   );

   modport slave (
      input  mult_start, mult_a, mult_b, mult_m,
      output mult_result, mult_done
   );
endinterface

// File: rtl/montexp_exp_shifter.sv
// Exponent walker: MSB-first left-shifting exponent register plus a down-counter
// flagging the final bit, so every exponent bit is visited with no zero skipping.
module montexp_exp_shifter
   import montexp_pkg::*;
#(
   parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [EXP_WIDTH-1:0] e_i,
   input  logic                 step_i,
   output logic                 bit_o,
   output logic                 last_o
);
   localparam int unsigned CW = cnt_width(EXP_WIDTH);

   logic [EXP_WIDTH-1:0] exp_q, exp_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   // Next-state: load a fresh exponent or move to the next lower bit.
   always_comb begin
      exp_d = exp_q;
      cnt_d = cnt_q;
      if (load_i) begin
         exp_d = e_i;
         cnt_d = CW'(EXP_WIDTH - 32'd1);
      end else if (step_i) begin
         exp_d = exp_q << 1;
         cnt_d = cnt_q - CW'(1'b1);
      end else begin
         exp_d = exp_q;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q <= '0;
         cnt_q <= '0;
      end else begin
         exp_q <= exp_d;
         cnt_q <= cnt_d;
      end
   end

   assign bit_o  = exp_q[EXP_WIDTH-1];
   assign last_o = (cnt_q == '0);
endmodule

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply controller sequencing an external Montgomery
// multiplier; MONTEXP_FINAL_CONVERT_EN adds a closing A*1 step out of the Montgomery domain.
module montgomery_exp
   import montexp_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [EXP_WIDTH-1:0] in_e,
   input  logic [WIDTH-1:0]     in_m,
   input  logic [WIDTH-1:0]     in_r,
   output logic [WIDTH-1:0]     result,
   output logic                 done,
   output logic                 busy,
   montgomery_exp_if.master     mult
);
`ifdef MONTEXP_FINAL_CONVERT_EN
   localparam state_e FINAL_ST = ST_CONV_ISSUE;
`else
   localparam state_e FINAL_ST = ST_DONE;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] mult_a_q, mult_a_d;
   logic [WIDTH-1:0] mult_b_q, mult_b_d;
   logic             mult_start_q, mult_start_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             accept_s, step_s, cur_bit_s, last_s;

   montexp_exp_shifter #(.EXP_WIDTH(EXP_WIDTH)) u_shifter (
      .clk    (clk),
      .rst    (reset),
      .load_i (accept_s),
      .e_i    (in_e),
      .step_i (step_s),
      .bit_o  (cur_bit_s),
      .last_o (last_s)
   );

   // Next-state, accumulator update and registered-output next values.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      x_d      = x_q;
      m_d      = m_q;
      accept_s = 1'b0;
      step_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept_s = 1'b1;
               x_d      = in_x;
               m_d      = in_m;
               acc_d    = in_r;
               state_d  = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD:      state_d = ST_SQ_ISSUE;
         ST_SQ_ISSUE:  state_d = ST_SQ_WAIT;
         ST_SQ_WAIT: begin
            if (mult.mult_done) begin
               acc_d = mult.mult_result;
               if (cur_bit_s) begin
                  state_d = ST_MUL_ISSUE;
               end else begin
                  step_s  = 1'b1;
                  state_d = last_s ? FINAL_ST : ST_SQ_ISSUE;
               end
            end else begin
               state_d = ST_SQ_WAIT;
            end
         end
         ST_MUL_ISSUE: state_d = ST_MUL_WAIT;
         ST_MUL_WAIT: begin
            if (mult.mult_done) begin
               acc_d   = mult.mult_result;
               step_s  = 1'b1;
               state_d = last_s ? FINAL_ST : ST_SQ_ISSUE;
            end else begin
               state_d = ST_MUL_WAIT;
            end
         end
`ifdef MONTEXP_FINAL_CONVERT_EN
         ST_CONV_ISSUE: state_d = ST_CONV_WAIT;
         ST_CONV_WAIT: begin
            if (mult.mult_done) begin
               acc_d   = mult.mult_result;
               state_d = ST_DONE;
            end else begin
               state_d = ST_CONV_WAIT;
            end
         end
`endif
         ST_DONE:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase

      // Operands are loaded on entry to an ISSUE state and then held through the wait.
      mult_a_d     = mult_a_q;
      mult_b_d     = mult_b_q;
      mult_start_d = 1'b0;
      case (state_d)
         ST_SQ_ISSUE: begin
            mult_start_d = 1'b1;
            mult_a_d     = acc_d;
            mult_b_d     = acc_d;
         end
         ST_MUL_ISSUE: begin
            mult_start_d = 1'b1;
            mult_a_d     = acc_d;
            mult_b_d     = x_d;
         end
`ifdef MONTEXP_FINAL_CONVERT_EN
         ST_CONV_ISSUE: begin
            mult_start_d = 1'b1;
            mult_a_d     = acc_d;
            mult_b_d     = WIDTH'(1'b1);
         end
`endif
         default: mult_start_d = 1'b0;
      endcase

      result_d = (state_d == ST_DONE) ? acc_d : result_q;
      done_d   = (state_d == ST_DONE);
      busy_d   = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         acc_q        <= '0;
         x_q          <= '0;
         m_q          <= '0;
         result_q     <= '0;
         mult_a_q     <= '0;
         mult_b_q     <= '0;
         mult_start_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         x_q          <= x_d;
         m_q          <= m_d;
         result_q     <= result_d;
         mult_a_q     <= mult_a_d;
         mult_b_q     <= mult_b_d;
         mult_start_q <= mult_start_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   assign result          = result_q;
   assign done            = done_q;
   assign busy            = busy_q;
   assign mult.mult_start = mult_start_q;
   assign mult.mult_a     = mult_a_q;
   assign mult.mult_b     = mult_b_q;
   assign mult.mult_m     = m_q;
endmodule

// File: tb/tb_montgomery_exp.sv
// Self-checking bench: behavioural Montgomery multiplier (R = 2^8) with programmable
// latency, plain-arithmetic exponentiation reference, and a per-cycle output monitor.
module tb_montgomery_exp;
   localparam int unsigned WIDTH     = 8;
   localparam int unsigned EXP_WIDTH = 4;
`ifdef MONTEXP_FINAL_CONVERT_EN
   localparam int CONV = 1;
`else
   localparam int CONV = 0;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [WIDTH-1:0]     in_x, in_m, in_r, result;
   logic [EXP_WIDTH-1:0] in_e;
   logic                 done, busy;

   montgomery_exp_if #(.WIDTH(WIDTH)) mif();

   montgomery_exp #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
      .clk(clk), .reset(reset), .start(start), .in_x(in_x), .in_e(in_e),
      .in_m(in_m), .in_r(in_r), .result(result), .done(done), .busy(busy),
      .mult(mif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mult_w = 3;
   bit spur_en = 1'b0;
   int pulse_cnt = 0;
   int busy_cnt = 0;
   bit done_seen = 1'b0;
   int exp_res = 0;
   bit sq_only = 1'b0;
   logic [WIDTH-1:0] op_a, op_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic int rinv(input int m);
      for (int i = 1; i < m; i++)
         if ((256 * i) % m == 1) return i;
      return 0;
   endfunction

   function automatic int mont_mul(input int a, input int b, input int m);
      return ((a * b) % m) * rinv(m) % m;
   endfunction

   // Reference: leave the Montgomery domain, exponentiate plainly, re-enter unless converting.
   function automatic int ref_exp(input int x, input int e, input int m);
      int xn = (x * rinv(m)) % m;
      int p  = 1;
      for (int i = 0; i < e; i++) p = (p * xn) % m;
      return (CONV != 0) ? p : (p * (256 % m)) % m;
   endfunction

   // Multiplier model: result after W wait cycles, optional spurious done outside waits.
   initial begin
      int cnt;
      cnt = 0;
      mif.mult_done   = 1'b0;
      mif.mult_result = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cnt = 0;
            mif.mult_done = 1'b0;
         end else if (mif.mult_start) begin
            mif.mult_result = WIDTH'(mont_mul(int'(mif.mult_a), int'(mif.mult_b), int'(mif.mult_m)));
            cnt = (mult_w == 0) ? int'($urandom_range(1, 5)) : mult_w;
            mif.mult_done = spur_en && ($urandom_range(0, 2) == 0);
         end else if (cnt > 0) begin
            mif.mult_done = (cnt == 1);
            cnt--;
         end else begin
            mif.mult_done = spur_en && ($urandom_range(0, 2) == 0);
         end
      end
   end

   // Compare process: launch operands, operand stability, busy accounting, result at done.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (mif.mult_start) begin
               pulse_cnt++;
               op_a = mif.mult_a;
               op_b = mif.mult_b;
               check("mult_m", 32'(mif.mult_m), 32'(in_m));
               if (sq_only && pulse_cnt <= int'(EXP_WIDTH))
                  check("square_a_eq_b", 32'(mif.mult_a), 32'(mif.mult_b));
            end else if (busy && pulse_cnt > 0) begin
               check("hold_a", 32'(mif.mult_a), 32'(op_a));
               check("hold_b", 32'(mif.mult_b), 32'(op_b));
            end
            if (busy) busy_cnt++;
            if (done) begin
               done_seen = 1'b1;
               check("result", 32'(result), 32'(exp_res));
               check("busy_at_done", 32'(busy), 32'd1);
            end
         end
      end
   end

   task automatic launch(input int x, input int e);
      @(negedge clk);
      pulse_cnt = 0;
      busy_cnt  = 0;
      done_seen = 1'b0;
      in_x  = WIDTH'(x);
      in_e  = EXP_WIDTH'(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_op(input string tag, input int e, input int w);
      int n = 0;
      int nmul = int'(EXP_WIDTH) + $countones(EXP_WIDTH'(e)) + CONV;
      while (!done_seen && n < 2000) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
      @(negedge clk); #1;
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
      check({tag, "_done_fall"}, 32'(done), 32'd0);
      check({tag, "_pulses"}, 32'(pulse_cnt), 32'(nmul));
      if (w != 0) check({tag, "_latency"}, 32'(busy_cnt), 32'(2 + nmul * (1 + w)));
   endtask

   task automatic wait_pulses(input int k);
      int n = 0;
      while (pulse_cnt < k && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      check("wait_pulses", 32'(pulse_cnt >= k), 32'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      in_x = 8'd5; in_e = 4'd0; in_m = 8'd13; in_r = 8'd9;
      repeat (2) @(negedge clk);
      check("rst_result", 32'(result), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mstart", 32'(mif.mult_start), 32'd0);
      check("rst_a", 32'(mif.mult_a), 32'd0);
      check("rst_b", 32'(mif.mult_b), 32'd0);
      check("rst_m", 32'(mif.mult_m), 32'd0);
      reset = 1'b0;

      check("model_e5", 32'(ref_exp(5, 5, 13)), (CONV != 0) ? 32'd6 : 32'd2);
      check("model_e0", 32'(ref_exp(5, 0, 13)), (CONV != 0) ? 32'd1 : 32'd9);
      check("model_eF", 32'(ref_exp(5, 15, 13)), (CONV != 0) ? 32'd8 : 32'd7);

      mult_w = 3; spur_en = 1'b0; sq_only = 1'b0;
      exp_res = (CONV != 0) ? 6 : 2;
      launch(5, 5);
      finish_op("e5", 5, 3);
      check("e5_latency_lit", 32'(busy_cnt), (CONV != 0) ? 32'd30 : 32'd26);
      check("e5_pulses_lit", 32'(pulse_cnt), (CONV != 0) ? 32'd7 : 32'd6);

      sq_only = 1'b1; exp_res = (CONV != 0) ? 1 : 9;
      launch(5, 0);
      finish_op("e0", 0, 3);
      sq_only = 1'b0;

      mult_w = 2; exp_res = (CONV != 0) ? 8 : 7;
      launch(5, 15);
      finish_op("eF", 15, 2);
      check("eF_pulses_lit", 32'(pulse_cnt), (CONV != 0) ? 32'd9 : 32'd8);

      // A second start during SQ_WAIT with different operands must be ignored.
      mult_w = 3; exp_res = (CONV != 0) ? 6 : 2;
      launch(5, 5);
      wait_pulses(1);
      @(negedge clk);
      in_x = 8'd7; in_e = 4'hF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_op("busy_start", 5, 3);

      // Asynchronous reset during MUL_WAIT, then a clean rerun.
      launch(5, 5);
      wait_pulses(3);
      @(negedge clk); #1;
      reset = 1'b1; #1;
      check("mid_rst_result", 32'(result), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_mstart", 32'(mif.mult_start), 32'd0);
      check("mid_rst_a", 32'(mif.mult_a), 32'd0);
      check("mid_rst_b", 32'(mif.mult_b), 32'd0);
      check("mid_rst_m", 32'(mif.mult_m), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      launch(5, 5);
      finish_op("after_rst", 5, 3);

      mult_w = 0; spur_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         int x = int'($urandom_range(0, 12));
         int e = int'($urandom_range(0, 15));
         exp_res = ref_exp(x, e, 13);
         launch(x, e);
         finish_op("rand", e, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
